// File: rtl/ram_master.sv
// ram_master: burst master for a 256x16 single-port synchronous RAM.
// A host issues read or write bursts of 1..16 beats. Write beats are
// streamed to the RAM as they arrive. Read beats are issued one per cycle
// and returned one cycle later, with no backpressure. The address counter
// wraps from 0xFF to 0x00 inside a burst.
// Optional feature: define RAM_MASTER_BEATCNT_EN to add o_beat_count, a
// saturating count of completed beats.
module ram_master (
  input  logic        i_clock,
  input  logic        i_reset,
  // host request channel
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [7:0]  i_req_addr,
  input  logic [3:0]  i_req_len,
  // host write data channel
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  // host read data channel
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_busy,
`ifdef RAM_MASTER_BEATCNT_EN
  output logic [15:0] o_beat_count,
`endif
  // RAM side
  output logic        o_mem_enable,
  output logic        o_mem_read_write,
  output logic [7:0]  o_mem_addr,
  output logic [15:0] o_mem_data_in,
  input  logic [15:0] i_mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_addr;
  logic [3:0]  r_remaining;
  logic        r_rd_valid;

  logic        w_accept;
  logic        w_issue;
  logic        w_wr_beat;
  logic        w_req_ready;
  logic        w_wr_ready;
  logic        w_mem_enable;
  logic        w_mem_read_write;
  logic [7:0]  w_mem_addr;
  logic [15:0] w_mem_data_in;

  // State register; reset wins over any request in the same cycle.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state and RAM/host handshake decode.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // through the case leaves one unassigned, which would infer a latch.
    w_next_state     = r_state;
    w_accept         = 1'b0;
    w_issue          = 1'b0;
    w_wr_beat        = 1'b0;
    w_req_ready      = 1'b0;
    w_wr_ready       = 1'b0;
    w_mem_enable     = 1'b0;
    w_mem_read_write = 1'b1;
    w_mem_addr       = 8'h00;
    w_mem_data_in    = 16'h0000;

    unique case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept     = 1'b1;
          w_next_state = i_req_write ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        w_wr_ready = 1'b1;
        if (i_wr_valid) begin
          w_issue          = 1'b1;
          w_wr_beat        = 1'b1;
          w_mem_enable     = 1'b1;
          w_mem_read_write = 1'b0;
          w_mem_addr       = r_addr;
          w_mem_data_in    = i_wr_data;
          if (r_remaining == 4'd0) w_next_state = S_IDLE;
        end
      end

      S_READ: begin
        w_issue          = 1'b1;
        w_mem_enable     = 1'b1;
        w_mem_read_write = 1'b1;
        w_mem_addr       = r_addr;
        if (r_remaining == 4'd0) w_next_state = S_DRAIN;
      end

      S_DRAIN: begin
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Address and remaining-beat counters: loaded on accept, stepped per beat.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_addr      <= 8'h00;
      r_remaining <= 4'd0;
    end else if (w_accept) begin
      r_addr      <= i_req_addr;
      r_remaining <= i_req_len;
    end else if (w_issue) begin
      r_addr      <= r_addr + 8'd1;
      r_remaining <= r_remaining - 4'd1;
    end
  end

  // Read-data valid trails each READ issue cycle by exactly one cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_rd_valid <= 1'b0;
    else         r_rd_valid <= (r_state == S_READ);
  end

`ifdef RAM_MASTER_BEATCNT_EN
  logic [15:0] r_beat_count;
  logic        w_beat_done;

  assign w_beat_done = w_wr_beat | r_rd_valid;

  // Saturating count of completed write beats and returned read beats.
  always_ff @(posedge i_clock) begin
    if (i_reset)                                    r_beat_count <= 16'h0000;
    else if (w_beat_done && r_beat_count != 16'hFFFF) r_beat_count <= r_beat_count + 16'd1;
  end

  assign o_beat_count = r_beat_count;
`endif

  assign o_req_ready      = w_req_ready;
  assign o_wr_ready       = w_wr_ready;
  assign o_busy           = (r_state != S_IDLE);
  assign o_rd_valid       = r_rd_valid;
  assign o_rd_data        = r_rd_valid ? i_mem_data_out : 16'h0000;
  assign o_mem_enable     = w_mem_enable;
  assign o_mem_read_write = w_mem_read_write;
  assign o_mem_addr       = w_mem_addr;
  assign o_mem_data_in    = w_mem_data_in;

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed and randomized bursts against ram_master driving a
// behavioural 256x16 RAM. The stimulus side predicts every RAM access and
// every read beat from a reference memory image and pushes them onto queues;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ram_master;

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] data;
  } mem_op_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        mem_enable;
  logic        mem_read_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
`ifdef RAM_MASTER_BEATCNT_EN
  logic [15:0] beat_count;
`endif

  ram_master dut (
    .i_clock          (clk),
    .i_reset          (reset),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_addr       (req_addr),
    .i_req_len        (req_len),
    .i_wr_data        (wr_data),
    .i_wr_valid       (wr_valid),
    .o_wr_ready       (wr_ready),
    .o_rd_data        (rd_data),
    .o_rd_valid       (rd_valid),
    .o_busy           (busy),
`ifdef RAM_MASTER_BEATCNT_EN
    .o_beat_count     (beat_count),
`endif
    .o_mem_enable     (mem_enable),
    .o_mem_read_write (mem_read_write),
    .o_mem_addr       (mem_addr),
    .o_mem_data_in    (mem_data_in),
    .i_mem_data_out   (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM: data appears one cycle after a read issue.
  logic [15:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    mem_data_out = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_enable) begin
      if (!mem_read_write) ram[mem_addr] <= mem_data_in;
      else                 mem_data_out  <= ram[mem_addr];
    end
  end

  // Reference memory image and scoreboard queues.
  logic [15:0] ref_mem [256];
  mem_op_t     exp_ops[$];
  logic [15:0] exp_rd[$];
  int          n_compared;
  int          n_mismatched;
  bit          mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_compared++;
    n_mismatched++;
    $display("FAIL %s: got an unexpected event, expected none at %0t", name, $time);
  endtask

  // Monitor: every RAM access and every read beat must match the prediction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_enable === 1'b1) begin
        if (exp_ops.size() == 0) begin
          note_fail("mem_op_unexpected");
        end else begin
          mem_op_t op;
          op = exp_ops.pop_front();
          check("mem_op", {7'd0, mem_read_write, mem_addr, op.rw ? 16'h0 : mem_data_in},
                          {7'd0, op.rw, op.addr, op.rw ? 16'h0 : op.data});
        end
      end else begin
        check("mem_idle_bus", {7'd0, mem_read_write, mem_addr, mem_data_in},
                              {7'd0, 1'b1, 8'h00, 16'h0000});
      end
      if (rd_valid === 1'b1) begin
        if (exp_rd.size() == 0) note_fail("rd_unexpected");
        else                    check("rd_data", {16'd0, rd_data}, {16'd0, exp_rd.pop_front()});
      end
    end
  end

  // Wait (bounded) until the DUT is idle; called just after a posedge.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) note_fail("idle_timeout");
  endtask

  // Present one request and let it be accepted on the next posedge.
  task automatic issue_req(input logic wr, input logic [7:0] addr, input logic [3:0] len);
    wait_idle();
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = $urandom();
    req_len   = $urandom();
  endtask

  // Write burst: data[i] = base + i, or random; up to max_stall idle cycles before each beat.
  task automatic do_write(input logic [7:0] addr, input logic [3:0] len,
                          input bit rand_data, input logic [15:0] base, input int max_stall);
    logic [7:0]  a;
    logic [15:0] d;
    issue_req(1'b1, addr, len);
    check("busy_after_wr_accept", {31'd0, busy}, 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      d = rand_data ? 16'($urandom()) : base + 16'(i);
      exp_ops.push_back('{rw: 1'b0, addr: a, data: d});
      ref_mem[a] = d;
      if (max_stall > 0) begin
        int k;
        k = $urandom_range(0, max_stall);
        wr_valid = 1'b0;
        for (int s = 0; s < k; s++) begin
          @(negedge clk);
          check("wr_ready_stall", {31'd0, wr_ready}, 32'd1);
          @(posedge clk); #1;
        end
      end
      wr_valid = 1'b1;
      wr_data  = d;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wr_data  = $urandom();
    @(negedge clk);
    check("busy_after_last_wr", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Read burst: RdValid on cycles 2..len+2 after acceptance, ReqReady after DRAIN.
  task automatic do_read(input logic [7:0] addr, input logic [3:0] len);
    logic [7:0] a;
    issue_req(1'b0, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      exp_ops.push_back('{rw: 1'b1, addr: a, data: 16'h0});
      exp_rd.push_back(ref_mem[a]);
    end
    for (int c = 1; c <= int'(len) + 3; c++) begin
      @(negedge clk);
      check("rd_valid_timing", {31'd0, rd_valid}, {31'd0, (c >= 2 && c <= int'(len) + 2)});
      if (c == int'(len) + 3) check("req_ready_after_drain", {31'd0, req_ready}, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    mon_en       = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_len   = 4'd0;
    wr_data   = 16'h0000;
    wr_valid  = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_wr_ready",   {31'd0, wr_ready},   32'd0);
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed: write 0x10..0x13, read it back.
    do_write(8'h10, 4'd3, 1'b0, 16'hA000, 0);
    do_read(8'h10, 4'd3);
`ifdef RAM_MASTER_BEATCNT_EN
    check("beat_count", {16'd0, beat_count}, 32'd8);
`endif

    // Directed: address wrap inside a burst, then read back across the wrap.
    do_write(8'hFE, 4'd2, 1'b0, 16'h5150, 0);
    do_read(8'hFE, 4'd2);

    // Directed: two-beat write with a three-cycle stall between beats.
    begin
      issue_req(1'b1, 8'h40, 4'd1);
      exp_ops.push_back('{rw: 1'b0, addr: 8'h40, data: 16'hC0DE});
      exp_ops.push_back('{rw: 1'b0, addr: 8'h41, data: 16'hBEEF});
      ref_mem[8'h40] = 16'hC0DE;
      ref_mem[8'h41] = 16'hBEEF;
      wr_valid = 1'b1; wr_data = 16'hC0DE;
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_data = 16'h1234;
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        check("stall_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
      end
      wr_valid = 1'b1; wr_data = 16'hBEEF;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      @(negedge clk);
      check("stall_done_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      do_read(8'h40, 4'd1);
    end

    // Directed: reset during the second beat of a 16-beat read.
    begin
      logic [7:0] a0;
      a0 = 8'h80;
      issue_req(1'b0, a0, 4'd15);
      exp_ops.push_back('{rw: 1'b1, addr: a0,        data: 16'h0});
      exp_ops.push_back('{rw: 1'b1, addr: a0 + 8'd1, data: 16'h0});
      exp_rd.push_back(ref_mem[a0]);
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'h20;
      req_len   = 4'd0;
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("post_rst_busy",      {31'd0, busy},      32'd0);
      check("post_rst_rd_valid",  {31'd0, rd_valid},  32'd0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("post_rst_quiet", {30'd0, rd_valid, mem_enable}, 32'd0);
      end
      @(posedge clk); #1;
    end

    // Randomized bursts against the reference image.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] a;
      logic [3:0] l;
      a = 8'($urandom());
      if ($urandom_range(0, 3) == 0) a = 8'hF8 + 8'($urandom_range(0, 7));
      l = 4'($urandom());
      if ($urandom_range(0, 1) == 1) do_write(a, l, 1'b1, 16'h0, 2);
      else                           do_read(a, l);
    end

    repeat (4) @(posedge clk);
    #1;
    check("ops_drained", exp_ops.size(), 32'd0);
    check("rd_drained",  exp_rd.size(),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL: single clock, synchronous active-high reset; Clock (posedge) and Reset (sync, active-high) only.
REQ-002 SHALL: Clock  in  1  system clock.
REQ-003 SHALL: Reset  in  1  synchronous active-high reset.
REQ-004 SHALL: ReqValid  in  1  host burst request valid.
REQ-005 SHALL: ReqReady  out  1  request accepted when ReqValid & ReqReady.
REQ-006 SHALL: ReqWrite  in  1  1=write burst, 0=read burst.
REQ-007 SHALL: ReqAddr  in  8  burst start address.
REQ-008 SHALL: ReqLen  in  4  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-009 SHALL: WrData  in  16  write beat data; WrValid  in  1  beat present; WrReady  out  1  beat consumed when WrValid & WrReady.
REQ-010 SHALL: RdData  out  16  read beat data; RdValid  out  1  RdData valid this cycle (no backpressure).
REQ-011 SHALL: Busy  out  1  high whenever state is not IDLE.
REQ-012 SHALL: MemEnable, MemReadWrite (1=read)  out  1 each; MemAddr  out  8; MemDataIn  out  16; MemDataOut  in  16; these connect to the 256x16 RAM's Enable, ReadWrite, address, DataIn, DataOut.

Function
REQ-013 SHALL: state machine with states IDLE, WRITE, READ, DRAIN.
REQ-014 SHALL: IDLE: ReqReady=1; on ReqValid latch ReqAddr into address counter, ReqLen into remaining counter, go to WRITE if ReqWrite else READ.
REQ-015 SHALL: ReqReady=0 in every non-IDLE state; requests are not queued.
REQ-016 SHALL: WRITE: WrReady=1; each cycle with WrValid=1 drive MemEnable=1, MemReadWrite=0, MemAddr=address counter, MemDataIn=WrData (same cycle, combinational), then increment address and decrement remaining.
REQ-017 SHALL: WRITE with WrValid=0: MemEnable=0, address and remaining held (stall of any length).
REQ-018 SHALL: WRITE: beat with remaining=0 is last; next state IDLE.
REQ-019 SHALL: READ: drive MemEnable=1, MemReadWrite=1, MemAddr=address counter every cycle, one beat per cycle; increment address, decrement remaining; after beat with remaining=0 go to DRAIN.
REQ-020 SHALL: RdValid registered = 1 in the cycle after each READ issue cycle; RdData = MemDataOut in that cycle (read latency exactly one cycle after issue; first RdValid two cycles after request acceptance).
REQ-021 SHALL: DRAIN: one cycle; MemEnable=0; RdValid=1 for last beat; then IDLE (ReqReady=1 next cycle).
REQ-022 SHALL: address counter wraps 0xFF -> 0x00 inside a burst.
REQ-023 SHALL: MemEnable=0, WrReady=0 in IDLE and DRAIN; MemReadWrite=1, MemAddr=0, MemDataIn=0 whenever MemEnable=0.
REQ-024 SHALL: RdValid=0 in all cycles not following a READ issue.

Reset
REQ-025 SHALL: Reset=1 at posedge: state IDLE, address and remaining counters 0, RdValid=0; hence ReqReady=1, Busy=0, WrReady=0, MemEnable=0 from the following cycle.
REQ-026 SHALL: Reset mid-burst abandons the burst; no further MemEnable or RdValid for it; Reset has priority over ReqValid.

Configuration
REQ-027 SHALL: macro RAM_MASTER_BEATCNT_EN defined: extra output BeatCount  out  16, count of completed beats (write beats issued plus RdValid cycles), saturating at 0xFFFF, cleared by Reset.
REQ-028 SHALL: macro undefined: no BeatCount port and no counter logic; all other behaviour identical.

Verification
REQ-029 SHALL: reset, then write ReqAddr=0x10 ReqLen=3 with WrData 0xA000..0xA003 continuous -> MemEnable high 4 cycles, MemAddr 0x10..0x13, MemReadWrite=0, Busy low after last beat.
REQ-030 SHALL: read ReqAddr=0x10 ReqLen=3 -> RdValid 4 consecutive cycles starting 2 cycles after acceptance, RdData 0xA000..0xA003, ReqReady high the cycle after DRAIN.
REQ-031 SHALL: write ReqAddr=0xFE ReqLen=2 -> MemAddr 0xFE, 0xFF, 0x00.
REQ-032 SHALL: write ReqLen=1 with WrValid low 3 cycles between beats -> MemEnable only on 2 WrValid cycles, address held during stall.
REQ-033 SHALL: Reset asserted during beat 2 of a 16-beat read -> no RdValid after the reset cycle, ReqReady=1 next cycle; ReqValid with ReqLen=0 in reset cycle not accepted.
REQ-034 SHALL: with RAM_MASTER_BEATCNT_EN, REQ-029 then REQ-030 -> BeatCount=8.
